inst_fetch_port: RTL

// Parametrised instruction-memory access port between IF stage and a synchronous-read inst RAM.

---
 rtl/inst_fetch_port.sv | 110 +++++++++++
 1 files changed

// File: rtl/inst_fetch_port.sv
// Instruction-memory access port between IF stage and a synchronous-read inst RAM.
// Accept -> rsp_valid: WAIT_CYCLES+2 normal, 1 on exception; response held until i_rsp_ready.
module inst_fetch_port #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int RAM_AW      = 18,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              o_req_ready,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic [ADDR_W-1:0] o_rsp_addr,
  output logic [1:0]        o_rsp_exc,
  output logic              o_busy,
  output logic              o_ram_en,
  output logic [RAM_AW-1:0] o_ram_addr,
  input  logic [DATA_W-1:0] i_ram_rdata
);
  localparam int         OFF_W     = $clog2(DATA_W / 8);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic [DATA_W-1:0]   r_rsp_data;
  logic [ADDR_W-1:0]   r_rsp_addr;
  logic [1:0]          r_rsp_exc;

  logic                w_misalign;
  logic                w_out_of_range;
  logic [1:0]          w_exc;
  logic                w_req_ready;
  logic                w_accept;

  // Misalignment wins over range so a bad PC is reported by its cheapest cause.
  assign w_misalign     = |i_req_addr[OFF_W-1:0];
  assign w_out_of_range = |i_req_addr[ADDR_W-1:RAM_AW+OFF_W];
  assign w_exc          = w_misalign ? 2'b01 : (w_out_of_range ? 2'b10 : 2'b00);

  assign w_req_ready = !i_flush &&
                       ((r_state == S_IDLE) || ((r_state == S_RESP) && i_rsp_ready));
  assign w_accept    = i_req_valid && w_req_ready;

  assign o_req_ready = w_req_ready;
  assign o_ram_en    = w_accept && (w_exc == 2'b00);
  assign o_ram_addr  = i_req_addr[RAM_AW+OFF_W-1:OFF_W];
  assign o_rsp_valid = (r_state == S_RESP);
  assign o_busy      = (r_state != S_IDLE);
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_addr  = r_rsp_addr;
  assign o_rsp_exc   = r_rsp_exc;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (i_flush) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_accept) w_next = (w_exc != 2'b00) ? S_RESP : S_WAIT;
        S_WAIT: if (r_cnt == 4'd0) w_next = S_RESP;
        S_RESP: begin
          if (w_accept)         w_next = (w_exc != 2'b00) ? S_RESP : S_WAIT;
          else if (i_rsp_ready) w_next = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // A flushed fetch's RAM data is simply never captured: WAIT is left before cnt hits 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= 4'd0;
      r_rsp_data <= '0;
      r_rsp_addr <= '0;
      r_rsp_exc  <= 2'b00;
    end else if (i_flush) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_rsp_addr <= i_req_addr;
      if (w_exc != 2'b00) begin
        r_rsp_data <= '0;
        r_rsp_exc  <= w_exc;
      end else begin
        r_cnt <= WAIT_INIT;
      end
    end else if (r_state == S_WAIT) begin
      if (r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end else begin
        r_rsp_data <= i_ram_rdata;
        r_rsp_exc  <= 2'b00;
      end
    end
  end

endmodule
